mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the single 64-bit main-memory port between the instruction-fetch requester and the load/store data requester of the multicycle RISC-V core. Data accesses have priority, with a streak limit that bounds fetch starvation. The control state machine drives the requester handshakes. The arbiter owns the memory-side request/ready handshake, latches address and write data at grant, and returns read data to the granted requester.

## Interface
- MAX_DM_STREAK, 4: consecutive data grants allowed while a fetch is pending before fetch is forced; range 1..15.
- TIMEOUT_CYCLES, 64: busy-cycle limit before abort; used only with ARB_TIMEOUT_EN.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- IF_REQ  in  1  fetch request; held until IF_DONE.
- IF_ADDR  in  64  fetch byte address.
- IF_RDATA  out  32  fetched instruction word.
- IF_DONE  out  1  one-cycle completion pulse for fetch.
- DM_REQ  in  1  data request; held until DM_DONE.
- DM_WE  in  1  1 = store, 0 = load.
- DM_ADDR  in  64  data byte address.
- DM_WDATA  in  64  store data.
- DM_RDATA  out  64  load data.
- DM_DONE  out  1  one-cycle completion pulse for data.
- MEM_REQ  out  1  memory request, high for the whole transaction.
- MEM_WE  out  1  memory write enable.
- MEM_ADDR  out  64  memory address.
- MEM_WDATA  out  64  memory write data.
- MEM_RDATA  in  64  memory read data, valid with MEM_READY.
- MEM_READY  in  1  memory completion, sampled while MEM_REQ = 1.
- GRANT_DM  out  1  1 while the data requester owns the port.
- ARB_ERR  out  1  high with a DONE pulse when that transaction timed out.

## Operation
- The FSM has four states.
  - IDLE: samples requests.
  - BUSY_IF and BUSY_DM: transaction in progress.
  - DONE: completion pulse.
- IDLE arbitration:
  - DM_REQ only: grant DM.
  - IF_REQ only: grant IF.
  - Both: grant DM unless streak = MAX_DM_STREAK, then grant IF.
  - Neither: stay in IDLE.
- Streak counter, 4 bits:
  - Increments on a DM grant made while IF_REQ = 1.
  - Clears on any IF grant.
  - Clears on a DM grant made while IF_REQ = 0.
- At grant, MEM_ADDR, MEM_WE and MEM_WDATA are registered from the granted requester. A fetch forces MEM_WE = 0 and MEM_WDATA = 0. The registered values are held constant until DONE.
- BUSY_x to DONE on an edge where MEM_READY = 1:
  - Loads capture MEM_RDATA.
  - IF_RDATA = IF_ADDR[2] ? MEM_RDATA[63:32] : MEM_RDATA[31:0], using the latched address bit.
  - DM_RDATA takes the full 64 bits.
  - Stores leave DM_RDATA unchanged.
- DONE:
  - Pulses the matching x_DONE for one cycle and drops MEM_REQ.
  - Always returns to IDLE on the next edge.
  - The requester deasserts REQ in the cycle after DONE, or keeps it high to issue a new request, which IDLE then arbitrates.
- IF_RDATA and DM_RDATA hold their last captured value until overwritten.
- GRANT_DM = 1 in BUSY_DM, and in DONE after a DM transaction.
- REQ dropping during BUSY is a protocol violation. The transaction still completes and DONE still pulses.

## Timing
- Reset (RST = 0, asynchronous):
  - State goes to IDLE and the streak counter to 0.
  - Every output is 0: MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, IF_RDATA, DM_RDATA, IF_DONE, DM_DONE, GRANT_DM, ARB_ERR.
  - An in-flight transaction is abandoned and no DONE pulse is produced.
- Latency, taking the edge that samples REQ in IDLE as edge 0:
  - MEM_REQ is high from edge 0.
  - With MEM_READY high in the first busy cycle, DONE is high after edge 1.
  - IDLE follows after edge 2.
  - Minimum is 3 cycles per transaction. Each extra memory wait cycle adds one.
- All outputs are registered. There is no combinational path from REQ or MEM_READY to any output.
- MEM_READY while in IDLE or DONE is ignored.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A busy counter runs in BUSY_x.
  - When it reaches TIMEOUT_CYCLES without MEM_READY, the FSM moves to DONE with ARB_ERR = 1. Read data for the aborted requester is forced to 0.
  - If MEM_READY arrives on the limit edge, READY wins and ARB_ERR = 0.
  - The counter clears on entry to BUSY.
- ARB_TIMEOUT_EN undefined:
  - BUSY waits for MEM_READY indefinitely.
  - ARB_ERR is tied to 0.
  - No counter logic is present.

## Test plan
- Reset mid-transaction: hold DM_REQ = 1 with MEM_READY = 0, assert RST = 0 after 2 busy cycles -> MEM_REQ = 0 immediately, all outputs 0, no DM_DONE pulse; after reset release, a fresh request is granted from IDLE.
- Single fetch: IF_ADDR = 0x104, MEM_READY = 1 in the first busy cycle, MEM_RDATA = 0xAABBCCDD_11223344 -> IF_DONE pulses 2 cycles after the request is sampled, IF_RDATA = 0xAABBCCDD; repeat with IF_ADDR = 0x100 -> IF_RDATA = 0x11223344.
- Store: DM_WE = 1, DM_ADDR = 0x2000, DM_WDATA = 0xDEADBEEF_CAFEF00D, 3 wait cycles -> MEM_WE = 1 and MEM_ADDR/MEM_WDATA stable for 4 cycles, DM_DONE pulses once, DM_RDATA unchanged.
- Contention: IF_REQ and DM_REQ both held continuously, MAX_DM_STREAK = 4 -> grant order DM, DM, DM, DM, IF, repeating; the streak counter never exceeds 4.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8): DM load with MEM_READY never asserted -> DM_DONE and ARB_ERR high together after 8 busy cycles, DM_RDATA = 0; second run with MEM_READY on cycle 8 -> ARB_ERR = 0 and DM_RDATA = MEM_RDATA.
- Back-to-back fetch: IF_REQ kept high through DONE -> next grant occurs from IDLE, with exactly one idle cycle between MEM_REQ pulses.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// slave = arbiter view, master = requester/memory (testbench) view.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;

    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic [63:0] dm_rdata;
    logic        dm_done;

    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;

    logic        grant_dm;
    logic        arb_err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        output if_rdata, if_done, dm_rdata, dm_done, mem_req, mem_we, mem_addr, mem_wdata,
               grant_dm, arb_err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_done, dm_rdata, dm_done, mem_req, mem_we, mem_addr, mem_wdata,
               grant_dm, arb_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the 64-bit memory port between fetch and load/store, data first with a streak limit.
// Optional busy timeout enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int unsigned MAX_DM_STREAK  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    localparam int unsigned ADDR_W   = 64;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned INSN_W   = 32;
    localparam int unsigned STREAK_W = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_IF = 2'd1;
    localparam logic [1:0] ST_BUSY_DM = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    if (MAX_DM_STREAK < 1 || MAX_DM_STREAK > 15) begin : g_bad_streak
        $error("mem_port_arbiter: MAX_DM_STREAK must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]          state_q,     state_d;
    logic [STREAK_W-1:0] streak_q,    streak_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [INSN_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;
    logic                if_done_q,   if_done_d;
    logic                dm_done_q,   dm_done_d;
    logic                grant_dm_q,  grant_dm_d;
    logic                dm_wins_c;
    logic [INSN_W-1:0]   fetch_word_c;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
    logic             arb_err_q,  arb_err_d;
    logic             timeout_c;

    assign timeout_c = (busy_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Data wins unless fetch is waiting and the data streak has hit its limit.
    assign dm_wins_c = bus.dm_req &&
                       !(bus.if_req && (streak_q == STREAK_W'(MAX_DM_STREAK)));

    // Select the 32-bit instruction half using the latched address.
    assign fetch_word_c = mem_addr_q[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            grant_dm_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            grant_dm_q  <= grant_dm_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt_q <= '0;
            arb_err_q  <= 1'b0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
            arb_err_q  <= arb_err_d;
        end
    end
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        grant_dm_d  = grant_dm_q;
`ifdef ARB_TIMEOUT_EN
        busy_cnt_d  = busy_cnt_q;
        arb_err_d   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (dm_wins_c) begin
                    state_d     = ST_BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    grant_dm_d  = 1'b1;
                    streak_d    = bus.if_req ? (streak_q + STREAK_W'(1)) : '0;
`ifdef ARB_TIMEOUT_EN
                    busy_cnt_d  = '0;
`endif
                end else if (bus.if_req) begin
                    state_d     = ST_BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    grant_dm_d  = 1'b0;
                    streak_d    = '0;
`ifdef ARB_TIMEOUT_EN
                    busy_cnt_d  = '0;
`endif
                end
            end

            ST_BUSY_IF: begin
                if (bus.mem_ready) begin
                    state_d    = ST_DONE;
                    mem_req_d  = 1'b0;
                    if_done_d  = 1'b1;
                    if_rdata_d = fetch_word_c;
                end
`ifdef ARB_TIMEOUT_EN
                else if (timeout_c) begin
                    state_d    = ST_DONE;
                    mem_req_d  = 1'b0;
                    if_done_d  = 1'b1;
                    if_rdata_d = '0;
                    arb_err_d  = 1'b1;
                end else begin
                    busy_cnt_d = busy_cnt_q + CNT_W'(1);
                end
`endif
            end

            ST_BUSY_DM: begin
                if (bus.mem_ready) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    dm_done_d = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = bus.mem_rdata;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (timeout_c) begin
                    state_d    = ST_DONE;
                    mem_req_d  = 1'b0;
                    dm_done_d  = 1'b1;
                    dm_rdata_d = '0;
                    arb_err_d  = 1'b1;
                end else begin
                    busy_cnt_d = busy_cnt_q + CNT_W'(1);
                end
`endif
            end

            ST_DONE: begin
                state_d    = ST_IDLE;
                grant_dm_d = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.grant_dm  = grant_dm_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.arb_err   = arb_err_q;
`else
    assign bus.arb_err   = 1'b0;
`endif

endmodule
